spi_adc_reader: RTL and testbench

Parametrised SPI master receiver for serial ADC Pmods (Pmod ALS / ADC081S021 class), replacing the fixed 16-bit, 8-bit-data `spi_interface`. It runs configurable frames, strips the leading-zero and trailing bits, and checks the leading zeros. Results go out on a one-deep valid/ready holding register with overrun detection. It supports manual start and a periodic auto-sample mode, and feeds `double_dabble` / display logic downstream.

---
 rtl/spi_adc_pkg.sv | 21 ++
 rtl/spi_sclk_gen.sv | 60 ++++++
 rtl/spi_adc_reader.sv | 192 +++++++++++++++++++
 tb/tb_spi_adc_reader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_adc_pkg.sv
// Shared types and sizing helpers for the serial ADC reader.
package spi_adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_QUIET = 2'd3
  } state_e;

  // Bits needed to hold the values 0 .. v-1 (never less than 1).
  function automatic int unsigned clog2w(input int unsigned v);
    int unsigned w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock generator: CPOL=1 sclk built from a half-period down-counter,
// with strobes marking the edge where sclk rises and where a high half ends.
module spi_sclk_gen
  import spi_adc_pkg::*;
#(
  parameter int unsigned CLK_DIV_HALF = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  input  logic i_last_bit,
  output logic o_sclk,
  output logic o_rise,
  output logic o_high_end
);

  localparam int unsigned CW = clog2w(CLK_DIV_HALF);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV_HALF - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          tc;

  assign tc         = (cnt_q == '0);
  assign o_rise     = i_en && tc && !sclk_q;
  assign o_high_end = i_en && tc && sclk_q;
  assign o_sclk     = sclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (i_load) begin
      sclk_d = 1'b0;
      cnt_d  = HALF_M1;
    end else if (i_en) begin
      if (tc) begin
        cnt_d  = HALF_M1;
        // after the final high half sclk parks high instead of toggling
        sclk_d = (sclk_q && i_last_bit) ? 1'b1 : !sclk_q;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end else begin
      sclk_d = 1'b1;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sclk_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_adc_reader.sv
// SPI master receiver for serial ADCs: configurable frame, sample extraction,
// leading-zero check, one-deep valid/ready output and periodic auto-trigger.
//
// state    | meaning
// ST_IDLE  | cs high, waiting for i_Start or an auto trigger
// ST_SETUP | cs low, sclk high, cs-to-first-sclk-fall setup time
// ST_SHIFT | clocking FRAME_BITS bits in, Din sampled on sclk rise
// ST_QUIET | cs high, enforcing the gap before the next frame
module spi_adc_reader
  import spi_adc_pkg::*;
#(
  parameter int unsigned CLK_DIV_HALF = 26,
  parameter int unsigned FRAME_BITS   = 16,
  parameter int unsigned LEAD_ZEROS   = 3,
  parameter int unsigned DATA_LSB     = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CS_SETUP     = 2,
  parameter int unsigned QUIET_CYCLES = 20,
  parameter int unsigned AUTO_PERIOD  = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_Start,
  input  logic                  i_Auto_En,
  input  logic                  i_Clear,
  input  logic                  Din,
  output logic                  sclk,
  output logic                  cs,
  output logic [DATA_WIDTH-1:0] o_RX_Data,
  output logic                  o_RX_DV,
  input  logic                  i_RX_Ready,
  output logic                  o_Busy,
  output logic                  o_Overrun,
  output logic                  o_Frame_Err
);

  if (LEAD_ZEROS + DATA_WIDTH + DATA_LSB > FRAME_BITS) begin : g_param_check
    $error("spi_adc_reader: LEAD_ZEROS + DATA_WIDTH + DATA_LSB exceeds FRAME_BITS");
  end

  localparam int unsigned TMAX = (CS_SETUP > QUIET_CYCLES) ? CS_SETUP : QUIET_CYCLES;
  localparam int unsigned TW   = clog2w(TMAX);
  localparam int unsigned BW   = clog2w(FRAME_BITS);
  localparam int unsigned AW   = clog2w(AUTO_PERIOD);

  localparam logic [TW-1:0] SETUP_M1   = TW'(CS_SETUP - 1);
  // The one IDLE cycle before a relaunch counts toward the quiet gap.
  localparam logic [TW-1:0] QUIET_LOAD = TW'((QUIET_CYCLES >= 2) ? QUIET_CYCLES - 2 : 0);
  localparam logic [BW-1:0] BITS_M1    = BW'(FRAME_BITS - 1);
  localparam logic [AW-1:0] AUTO_M1    = AW'(AUTO_PERIOD - 1);

  state_e                  state_q, state_d;
  logic [TW-1:0]           tmr_q, tmr_d;
  logic [BW-1:0]           bits_q, bits_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic [AW-1:0]           auto_cnt_q, auto_cnt_d;
  logic                    pend_q, pend_d;
  logic                    cs_q, cs_d;
  logic                    busy_q, busy_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    dv_q, dv_d;
  logic                    ovr_q, ovr_d;
  logic                    ferr_q, ferr_d;

  logic sclk_load, sclk_en, sclk_rise, sclk_high_end;
  logic auto_tick, complete, lead_err;

  assign sclk_en  = (state_q == ST_SHIFT);
  assign lead_err = |(shreg_q >> (FRAME_BITS - LEAD_ZEROS));

  spi_sclk_gen #(
    .CLK_DIV_HALF (CLK_DIV_HALF)
  ) u_sclk_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (sclk_load),
    .i_en       (sclk_en),
    .i_last_bit (bits_q == '0),
    .o_sclk     (sclk),
    .o_rise     (sclk_rise),
    .o_high_end (sclk_high_end)
  );

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    bits_d     = bits_q;
    shreg_d    = shreg_q;
    cs_d       = cs_q;
    sclk_load  = 1'b0;
    complete   = 1'b0;
    auto_tick  = i_Auto_En && (auto_cnt_q == AUTO_M1);

    if (!i_Auto_En || auto_tick) auto_cnt_d = '0;
    else                         auto_cnt_d = auto_cnt_q + 1'b1;

    // In IDLE a pending trigger is always consumed, so it can only survive while busy.
    if (!i_Auto_En || state_q == ST_IDLE) pend_d = 1'b0;
    else if (auto_tick)                   pend_d = 1'b1;
    else                                  pend_d = pend_q;

    case (state_q)
      ST_IDLE: begin
        if (i_Start || auto_tick || pend_q) begin
          state_d = ST_SETUP;
          cs_d    = 1'b0;
          tmr_d   = SETUP_M1;
        end
      end
      ST_SETUP: begin
        if (tmr_q == '0) begin
          state_d   = ST_SHIFT;
          bits_d    = BITS_M1;
          sclk_load = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_SHIFT: begin
        if (sclk_rise) shreg_d = {shreg_q[FRAME_BITS-2:0], Din};
        if (sclk_high_end) begin
          if (bits_q == '0) begin
            state_d  = ST_QUIET;
            cs_d     = 1'b1;
            tmr_d    = QUIET_LOAD;
            complete = 1'b1;
          end else begin
            bits_d = bits_q - 1'b1;
          end
        end
      end
      ST_QUIET: begin
        if (tmr_q == '0) state_d = ST_IDLE;
        else             tmr_d   = tmr_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);

    data_d = data_q;
    dv_d   = dv_q;
    ovr_d  = i_Clear ? 1'b0 : ovr_q;
    ferr_d = i_Clear ? 1'b0 : ferr_q;
    if (complete) begin
      data_d = shreg_q[DATA_LSB +: DATA_WIDTH];
      dv_d   = 1'b1;
      if (dv_q && !i_RX_Ready) ovr_d  = 1'b1;
      if (lead_err)            ferr_d = 1'b1;
    end else if (dv_q && i_RX_Ready) begin
      dv_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tmr_q      <= '0;
      bits_q     <= '0;
      shreg_q    <= '0;
      auto_cnt_q <= '0;
      pend_q     <= 1'b0;
      cs_q       <= 1'b1;
      busy_q     <= 1'b0;
      data_q     <= '0;
      dv_q       <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      bits_q     <= bits_d;
      shreg_q    <= shreg_d;
      auto_cnt_q <= auto_cnt_d;
      pend_q     <= pend_d;
      cs_q       <= cs_d;
      busy_q     <= busy_d;
      data_q     <= data_d;
      dv_q       <= dv_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign cs          = cs_q;
  assign o_Busy      = busy_q;
  assign o_RX_Data   = data_q;
  assign o_RX_DV     = dv_q;
  assign o_Overrun   = ovr_q;
  assign o_Frame_Err = ferr_q;

endmodule

// File: tb/tb_spi_adc_reader.sv
// Directed bench for spi_adc_reader: a Pmod-style 16-bit instance and a
// 12-bit fast-clock instance, each driven by a small serial ADC model.
module tb_spi_adc_reader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start1, auto1, clear1, ready1, din1, sclk1, cs1, dv1, busy1, ovr1, ferr1;
  logic [7:0]  data1;
  logic        start2, auto2, clear2, ready2, din2, sclk2, cs2, dv2, busy2, ovr2, ferr2;
  logic [11:0] data2;

  spi_adc_reader #(
    .AUTO_PERIOD (2000)
  ) dut1 (
    .clk (clk), .rst_n (rst_n), .i_Start (start1), .i_Auto_En (auto1), .i_Clear (clear1),
    .Din (din1), .sclk (sclk1), .cs (cs1), .o_RX_Data (data1), .o_RX_DV (dv1),
    .i_RX_Ready (ready1), .o_Busy (busy1), .o_Overrun (ovr1), .o_Frame_Err (ferr1)
  );

  spi_adc_reader #(
    .CLK_DIV_HALF (1), .FRAME_BITS (12), .LEAD_ZEROS (0), .DATA_LSB (0), .DATA_WIDTH (12),
    .CS_SETUP (2), .QUIET_CYCLES (5), .AUTO_PERIOD (20)
  ) dut2 (
    .clk (clk), .rst_n (rst_n), .i_Start (start2), .i_Auto_En (auto2), .i_Clear (clear2),
    .Din (din2), .sclk (sclk2), .cs (cs2), .o_RX_Data (data2), .o_RX_DV (dv2),
    .i_RX_Ready (ready2), .o_Busy (busy2), .o_Overrun (ovr2), .o_Frame_Err (ferr2)
  );

  // ADC models: each sclk fall presents the next frame bit, MSB first.
  logic [15:0] word1 = '0;
  logic [11:0] word2 = '0;
  int fall1 = 0;
  int fall2 = 0;
  always @(negedge sclk1 or posedge cs1) if (cs1) fall1 <= 0; else fall1 <= fall1 + 1;
  always @(negedge sclk2 or posedge cs2) if (cs2) fall2 <= 0; else fall2 <= fall2 + 1;
  assign din1 = (fall1 >= 1 && fall1 <= 16) ? word1[16 - fall1] : 1'b0;
  assign din2 = (fall2 >= 1 && fall2 <= 12) ? word2[12 - fall2] : 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for cs low, then counts cs-low cycles and sclk rises until cs returns high.
  task automatic meas(input bit sel, output int wc, output int lo, output int rises);
    bit prev;
    wc = 0; lo = 0; rises = 0; prev = 1'b1;
    while ((sel ? cs2 : cs1) !== 1'b0 && wc < 5000) begin @(negedge clk); wc++; end
    while ((sel ? cs2 : cs1) === 1'b0 && lo < 5000) begin
      lo++;
      if ((sel ? sclk2 : sclk1) && !prev) rises++;
      prev = sel ? sclk2 : sclk1;
      @(negedge clk);
    end
    chk("frame_in_time", 32'((wc < 5000) && (lo < 5000)), 32'd1);
  endtask

  task automatic wait_idle(input bit sel);
    int n = 0;
    while ((sel ? busy2 : busy1) !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    chk("idle_in_time", 32'(n < 200), 32'd1);
  endtask

  task automatic pulse_start1();
    start1 = 1'b1; @(negedge clk); start1 = 1'b0;
  endtask

  initial begin
    int wc, lo, rises, r, n;
    bit prev;
    rst_n = 1'b0;
    start1 = 0; auto1 = 0; clear1 = 0; ready1 = 1;
    start2 = 0; auto2 = 0; clear2 = 0; ready2 = 1;
    repeat (3) @(negedge clk);

    chk("rst_cs",    32'(cs1),    32'd1);
    chk("rst_sclk",  32'(sclk1),  32'd1);
    chk("rst_data",  32'(data1),  32'd0);
    chk("rst_dv",    32'(dv1),    32'd0);
    chk("rst_busy",  32'(busy1),  32'd0);
    chk("rst_ovr",   32'(ovr1),   32'd0);
    chk("rst_ferr",  32'(ferr1),  32'd0);
    chk("rst_cs2",   32'(cs2),    32'd1);
    chk("rst_dv2",   32'(dv2),    32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Pmod ALS frame, consumer always ready
    word1 = 16'b0001_0100_1010_0000;
    pulse_start1();
    chk("als_busy", 32'(busy1), 32'd1);
    meas(0, wc, lo, rises);
    chk("als_cs_low", 32'(lo),    32'd834);
    chk("als_rises",  32'(rises), 32'd16);
    chk("als_data",   32'(data1), 32'h4A);
    chk("als_dv",     32'(dv1),   32'd1);
    chk("als_ferr",   32'(ferr1), 32'd0);
    @(negedge clk);
    chk("als_dv_drop", 32'(dv1), 32'd0);
    wait_idle(0);

    // bad leading zeros; a second start mid-frame must be dropped
    word1 = 16'b1010_0100_1010_0000;
    pulse_start1();
    repeat (100) @(negedge clk);
    pulse_start1();
    meas(0, wc, lo, rises);
    chk("ferr_data", 32'(data1), 32'h4A);
    chk("ferr_set",  32'(ferr1), 32'd1);
    wait_idle(0);
    n = 0;
    repeat (50) begin @(negedge clk); if (cs1 === 1'b0) n++; end
    chk("start_not_queued", 32'(n), 32'd0);
    clear1 = 1'b1; @(negedge clk); clear1 = 1'b0;
    chk("ferr_cleared", 32'(ferr1), 32'd0);

    // overrun: two frames without acceptance
    ready1 = 1'b0;
    word1 = 16'h04A0;
    pulse_start1();
    meas(0, wc, lo, rises);
    chk("ovr_first_data", 32'(data1), 32'h4A);
    chk("ovr_first_flag", 32'(ovr1),  32'd0);
    wait_idle(0);
    word1 = 16'h05B0;
    pulse_start1();
    meas(0, wc, lo, rises);
    chk("ovr_data", 32'(data1), 32'h5B);
    chk("ovr_dv",   32'(dv1),   32'd1);
    chk("ovr_flag", 32'(ovr1),  32'd1);
    ready1 = 1'b1;
    @(negedge clk);
    chk("ovr_accept_dv", 32'(dv1), 32'd0);
    clear1 = 1'b1; @(negedge clk); clear1 = 1'b0;
    chk("ovr_cleared", 32'(ovr1), 32'd0);
    wait_idle(0);

    // reset in the middle of the seventh bit
    word1 = 16'h04A0;
    pulse_start1();
    r = 0; n = 0; prev = 1'b1;
    while (r < 7 && n < 2000) begin
      @(negedge clk); n++;
      if (sclk1 && !prev) r++;
      prev = sclk1;
    end
    chk("abort_reached_bit7", 32'(r), 32'd7);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_cs",   32'(cs1),   32'd1);
    chk("abort_sclk", 32'(sclk1), 32'd1);
    chk("abort_dv",   32'(dv1),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_dv_after", 32'(dv1), 32'd0);
    word1 = 16'h05B0;
    pulse_start1();
    meas(0, wc, lo, rises);
    chk("post_abort_cs_low", 32'(lo),    32'd834);
    chk("post_abort_data",   32'(data1), 32'h5B);
    chk("post_abort_dv",     32'(dv1),   32'd1);
    wait_idle(0);

    // auto mode, period 2000 cycles
    word1 = 16'h04A0;
    auto1 = 1'b1;
    meas(0, wc, lo, rises);
    chk("auto_first_start", 32'(wc),    32'd2000);
    chk("auto_first_data",  32'(data1), 32'h4A);
    meas(0, wc, lo, rises);
    chk("auto_period",      32'(wc + lo), 32'd2000);
    chk("auto_second_low",  32'(lo),      32'd834);
    auto1 = 1'b0;
    wait_idle(0);

    // 12-bit instance, sclk period 2 cycles
    word2 = 12'hABC;
    start2 = 1'b1; @(negedge clk); start2 = 1'b0;
    meas(1, wc, lo, rises);
    chk("fast_cs_low", 32'(lo),    32'd26);
    chk("fast_rises",  32'(rises), 32'd12);
    chk("fast_data",   32'(data2), 32'hABC);
    chk("fast_dv",     32'(dv2),   32'd1);
    chk("fast_ferr",   32'(ferr2), 32'd0);
    wait_idle(1);

    // auto period shorter than a frame: back-to-back, gap equals QUIET_CYCLES
    word2 = 12'h5A3;
    auto2 = 1'b1;
    meas(1, wc, lo, rises);
    chk("b2b_first_start", 32'(wc),    32'd20);
    chk("b2b_first_data",  32'(data2), 32'h5A3);
    for (int k = 0; k < 3; k++) begin
      meas(1, wc, lo, rises);
      chk("b2b_gap",   32'(wc),    32'd5);
      chk("b2b_low",   32'(lo),    32'd26);
      chk("b2b_data",  32'(data2), 32'h5A3);
    end
    auto2 = 1'b0;
    n = 0;
    repeat (40) begin @(negedge clk); if (cs2 === 1'b0) n++; end
    chk("b2b_no_extra_frame", 32'(n),    32'd0);
    chk("b2b_no_overrun",     32'(ovr2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
